// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one pipelined 32x32->64 multiplier
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_ready   per-requester issue handshake (ready is one-hot or zero)
//   req_src1/req_src2     packed 32-bit operands, requester i at [32i+31:32i]
//   req_signed1/2         per-requester operand signedness
//   rsp_valid/rsp_ready   result handshake; rsp_data = product, rsp_id = requester
//   mul_src1/2, mul_signa/b, mul_in_en, mul_out_en, mul_aclr, mul_result
//                         connection to the external two-stage multiplier cell
//   perf_clr, perf_busy_cnt, perf_stall_cnt
//                         only with MUL_SHARE_ARBITER_PERF_CNT_EN defined
module mul_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
    input  logic                  perf_clr,
    output logic [31:0]           perf_busy_cnt,
    output logic [31:0]           perf_stall_cnt,
`endif
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_src1,
    input  logic [NUM_REQ*32-1:0] req_src2,
    input  logic [NUM_REQ-1:0]    req_signed1,
    input  logic [NUM_REQ-1:0]    req_signed2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [63:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           mul_src1,
    output logic [31:0]           mul_src2,
    output logic                  mul_signa,
    output logic                  mul_signb,
    output logic                  mul_in_en,
    output logic                  mul_out_en,
    output logic                  mul_aclr,
    input  logic [63:0]           mul_result
);

    logic                s1_vld, s2_vld;
    logic [ID_W-1:0]     s1_id, s2_id;
    logic [ID_W-1:0]     rr_ptr, ptr_nxt;
    logic [ID_W-1:0]     grant_idx, cand;
    logic                grant_any;
    logic [NUM_REQ-1:0]  grant;
    logic                adv;

    // The whole pipe moves together; it only freezes when a finished result
    // is sitting in the output stage and the consumer is not taking it.
    assign adv = !s2_vld || rsp_ready;

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ-1.
    // Grants are suppressed while frozen and while reset is asserted.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = rr_ptr;
        if (adv && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
                cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
            end
        end
    end

    always_comb begin
        grant     = '0;
        mul_src1  = '0;
        mul_src2  = '0;
        mul_signa = 1'b0;
        mul_signb = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_any && (grant_idx == ID_W'(i));
            if (grant[i]) begin
                mul_src1  = req_src1[32*i +: 32];
                mul_src2  = req_src2[32*i +: 32];
                mul_signa = req_signed1[i];
                mul_signb = req_signed2[i];
            end
        end
    end

    assign ptr_nxt = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s1_id  <= '0;
            s2_id  <= '0;
            rr_ptr <= '0;
        end else if (adv) begin
            s2_vld <= s1_vld;
            s2_id  <= s1_id;
            s1_vld <= grant_any;
            s1_id  <= grant_idx;
            if (grant_any) begin
                rr_ptr <= ptr_nxt;
            end
        end
    end

    assign req_ready  = grant;
    assign mul_in_en  = adv;
    assign mul_out_en = adv;
    assign mul_aclr   = reset;
    assign rsp_valid  = s2_vld;
    assign rsp_data   = mul_result;
    assign rsp_id     = s2_id;

`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
    // Saturating counters; a clear request wins over a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_busy_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else if (perf_clr) begin
            perf_busy_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if ((s1_vld || s2_vld) && perf_busy_cnt != 32'hFFFF_FFFF) begin
                perf_busy_cnt <= perf_busy_cnt + 32'd1;
            end
            if (!adv && (|req_valid) && perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench for mul_share_arbiter
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_src1, req_src2;
    logic [NUM_REQ-1:0]    req_signed1, req_signed2;
    logic                  rsp_valid, rsp_ready;
    logic [63:0]           rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           mul_src1, mul_src2;
    logic                  mul_signa, mul_signb, mul_in_en, mul_out_en, mul_aclr;
    logic [63:0]           mul_result;
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
    logic                  perf_clr;
    logic [31:0]           perf_busy_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
        .perf_clr(perf_clr), .perf_busy_cnt(perf_busy_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2),
        .req_signed1(req_signed1), .req_signed2(req_signed2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .mul_src1(mul_src1), .mul_src2(mul_src2),
        .mul_signa(mul_signa), .mul_signb(mul_signb),
        .mul_in_en(mul_in_en), .mul_out_en(mul_out_en),
        .mul_aclr(mul_aclr), .mul_result(mul_result)
    );

    // Behavioural two-stage multiplier cell.
    logic [31:0] ma, mb;
    logic        msa, msb;
    logic [63:0] mres;

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb);
        logic signed [32:0] ea, eb;
        logic signed [65:0] p;
        ea = {sa & a[31], a};
        eb = {sb & b[31], b};
        p  = ea * eb;
        return p[63:0];
    endfunction

    always @(posedge clk or posedge mul_aclr) begin
        if (mul_aclr) begin
            ma <= '0; mb <= '0; msa <= 1'b0; msb <= 1'b0; mres <= '0;
        end else begin
            if (mul_out_en) mres <= mul_ref(ma, mb, msa, msb);
            if (mul_in_en) begin
                ma <= mul_src1; mb <= mul_src2; msa <= mul_signa; msb <= mul_signb;
            end
        end
    end
    assign mul_result = mres;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [63:0] d);
        exp_t e;
        e.id   = ID_W'(id);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            req_valid = '0;
        end
    endtask

    // Response monitor: every accepted response must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h expected none", rsp_id, rsp_data);
            end else begin
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_data !== e.data) begin
                    bad++;
                    $display("FAIL rsp: got id=%0d data=%h expected id=%0d data=%h",
                             rsp_id, rsp_data, e.id, e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; rsp_ready = 1'b1;
        req_valid = 2'b11; req_src1 = '0; req_src2 = '0;
        req_signed1 = '0; req_signed2 = '0;
`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_in_en", mul_in_en, 1);
        chk("rst_out_en", mul_out_en, 1);
        chk("rst_aclr", mul_aclr, 1);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_src1", mul_src1, 0);
        cyc();
        reset = 1'b0; req_valid = '0;
        idle(2);

        // Round robin: both requesters held valid for six cycles.
        for (int c = 0; c < 9; c++) begin
            cyc();
            if (c < 6) begin
                req_valid = 2'b11;
                req_src1  = {32'h0001_0000, 32'd3};
                req_src2  = {32'h0001_0000, 32'd5};
                push_exp(c % 2, (c % 2) ? 64'h1_0000_0000 : 64'd15);
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            chk("rr_ready", req_ready, (c < 6) ? ((c % 2) ? 64'd2 : 64'd1) : 64'd0);
            chk("rr_rsp_valid", rsp_valid, (c >= 2 && c < 8) ? 64'd1 : 64'd0);
        end
        idle(2);

        // Unsigned basic, latency 2.
        cyc();
        req_valid = 2'b01; req_src1 = {32'd0, 32'd7}; req_src2 = {32'd0, 32'd6};
        req_signed1 = '0; req_signed2 = '0;
        push_exp(0, 64'd42);
        @(negedge clk);
        chk("basic_ready", req_ready, 1);
        chk("basic_in_en", mul_in_en, 1);
        cyc(); req_valid = '0;
        @(negedge clk);
        chk("basic_t1_valid", rsp_valid, 0);
        cyc();
        @(negedge clk);
        chk("basic_t2_valid", rsp_valid, 1);
        idle(2);

        // Signedness: same operands, signed then unsigned.
        cyc();
        req_valid = 2'b01; req_src1 = {32'd0, 32'hFFFF_FFFF}; req_src2 = {32'd0, 32'd2};
        req_signed1 = 2'b01; req_signed2 = 2'b01;
        push_exp(0, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        chk("sgn_ready0", req_ready, 1);
        cyc();
        req_signed1 = '0; req_signed2 = '0;
        push_exp(0, 64'h0000_0001_FFFF_FFFE);
        @(negedge clk);
        chk("sgn_ready1", req_ready, 1);
        idle(4);

        // Back-pressure with three ops from requester 1.
        cyc();
        req_valid = 2'b10; req_src1 = {32'd100, 32'd0}; req_src2 = {32'd200, 32'd0};
        req_signed1 = '0; req_signed2 = '0;
        push_exp(1, 64'd20000);
        @(negedge clk);
        chk("bp_ready_a", req_ready, 2);
        cyc();
        req_src1 = {32'h8000_0000, 32'd0}; req_src2 = {32'd2, 32'd0};
        req_signed1 = 2'b10;
        push_exp(1, 64'hFFFF_FFFF_0000_0000);
        @(negedge clk);
        chk("bp_ready_b", req_ready, 2);
        cyc();
        req_src1 = {32'hFFFF_FFFF, 32'd0}; req_src2 = {32'hFFFF_FFFF, 32'd0};
        req_signed1 = '0; rsp_ready = 1'b0;
        push_exp(1, 64'hFFFF_FFFE_0000_0001);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) cyc();
            @(negedge clk);
            chk("bp_ready_stall", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_in_en", mul_in_en, 0);
            chk("bp_out_en", mul_out_en, 0);
            chk("bp_rsp_data", rsp_data, 64'd20000);
            chk("bp_rsp_id", rsp_id, 1);
        end
        cyc(); rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_c", req_ready, 2);
        cyc(); req_valid = '0;
        @(negedge clk);
        chk("bp_drain_b", rsp_valid, 1);
        cyc();
        @(negedge clk);
        chk("bp_drain_c", rsp_valid, 1);
        cyc();
        @(negedge clk);
        chk("bp_drain_done", rsp_valid, 0);
        idle(2);

`ifdef MUL_SHARE_ARBITER_PERF_CNT_EN
        cyc(); perf_clr = 1'b1;
        cyc(); perf_clr = 1'b0;
        req_valid = 2'b01; req_src1 = {32'd0, 32'd2}; req_src2 = {32'd0, 32'd3};
        push_exp(0, 64'd6);
        cyc(); req_valid = '0;
        cyc(); rsp_ready = 1'b0;
        req_valid = 2'b01; req_src1 = {32'd0, 32'd4}; req_src2 = {32'd0, 32'd5};
        @(negedge clk);
        chk("perf_stall_ready", req_ready, 0);
        cyc();
        cyc(); rsp_ready = 1'b1;
        push_exp(0, 64'd20);
        @(negedge clk);
        chk("perf_ready_y", req_ready, 1);
        cyc(); req_valid = '0;
        cyc();
        cyc(); perf_clr = 1'b1;
        @(negedge clk);
        chk("perf_busy", perf_busy_cnt, 6);
        chk("perf_stall", perf_stall_cnt, 2);
        cyc(); perf_clr = 1'b0;
        @(negedge clk);
        chk("perf_busy_clr", perf_busy_cnt, 0);
        chk("perf_stall_clr", perf_stall_cnt, 0);
        idle(2);
`endif

        // Reset with both stages live; these two ops must never come out.
        cyc();
        req_valid = 2'b01; req_src1 = {32'd0, 32'd11}; req_src2 = {32'd0, 32'd13};
        cyc();
        cyc();
        reset = 1'b1; req_valid = 2'b11;
        req_src1 = {32'd0, 32'd9}; req_src2 = {32'd0, 32'd9};
        @(negedge clk);
        chk("rmf_rsp_valid", rsp_valid, 0);
        chk("rmf_aclr", mul_aclr, 1);
        chk("rmf_in_en", mul_in_en, 1);
        chk("rmf_req_ready", req_ready, 0);
        chk("rmf_rsp_data", rsp_data, 0);
        cyc();
        @(negedge clk);
        chk("rmf_req_ready2", req_ready, 0);
        cyc(); reset = 1'b0;
        push_exp(0, 64'd81);
        @(negedge clk);
        chk("rmf_first_grant", req_ready, 1);
        idle(6);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one pipelined 32x32->64 multiplier cell (input register stage plus output register stage, separate enables) among NUM_REQ requesters.
- Round-robin arbitration and valid/ready request handshake on the issue side.
- Tracks in-flight operations with a 2-stage scoreboard and returns each result with the requester ID.
- Stalls the multiplier enables when the response consumer back-pressures.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- ID_W, 1, response ID width; 2^ID_W >= NUM_REQ required.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_src1  in  NUM_REQ*32  operand A, requester i at [32i+31:32i].
- req_src2  in  NUM_REQ*32  operand B, same packing.
- req_signed1  in  NUM_REQ  operand A is signed.
- req_signed2  in  NUM_REQ  operand B is signed.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  64  product.
- rsp_id  out  ID_W  index of originating requester.
- mul_src1  out  32  to multiplier dataa.
- mul_src2  out  32  to multiplier datab.
- mul_signa  out  1  to multiplier signa.
- mul_signb  out  1  to multiplier signb.
- mul_in_en  out  1  input-register enable (ena0).
- mul_out_en  out  1  output-register enable (ena1).
- mul_aclr  out  1  multiplier async clear; equals reset.
- mul_result  in  64  multiplier output register.

Behaviour:
- Multiplier model: input regs load on a clk edge when mul_in_en=1. Output reg loads the product of the input regs on a clk edge when mul_out_en=1.
- Scoreboard registers:
  - s1_vld, s1_id: input stage holds a live op.
  - s2_vld, s2_id: output stage holds a live result.
  - rr_ptr: next-priority requester.
- Advance: adv = !s2_vld | rsp_ready (combinational). mul_in_en = mul_out_en = adv.
- On adv, at the clk edge:
  - s2_vld <= s1_vld; s2_id <= s1_id.
  - s1_vld <= |grant; s1_id <= grant index.
- When !adv: all enables 0, grant forced 0, scoreboard and multiplier hold.
- Arbitration (combinational, only when adv):
  - Grant the first requester with req_valid set, searching from rr_ptr upward and wrapping at NUM_REQ-1 -> 0.
  - req_ready = grant. Ready depends on valid; requesters must not make valid depend on ready.
  - rr_ptr <= granted index + 1 (wrapping to 0); unchanged when there is no grant.
- Operand mux: mul_src1/mul_src2/mul_signa/mul_signb come from the granted requester. With no grant, drive zeros.
- Response:
  - rsp_valid = s2_vld, rsp_data = mul_result, rsp_id = s2_id.
  - A transfer occurs when rsp_valid & rsp_ready.
  - rsp_data and rsp_id stay stable while rsp_valid & !rsp_ready.
- Latency: accepted in cycle T (req_valid & req_ready) -> rsp_valid in cycle T+2 with no back-pressure. Throughput is 1 op/cycle.
- Ordering: responses leave in acceptance order; there is no reordering.
- Simultaneous events: a response transfer and a new grant in the same cycle are both legal.
- rsp_ready low while s2_vld=0: pipeline still advances (bubble collapse). The stage-1 op moves to stage 2 and a new grant is allowed.
- Reset (any time, mid-operation included):
  - Immediately: s1_vld=s2_vld=0, rr_ptr=0, mul_aclr=1.
  - All outputs go to 0 except mul_in_en=mul_out_en=1 (adv=1).
  - In-flight ops are discarded with no response. No grant is issued while reset is high.
- NUM_REQ=1: arbiter degenerates to pass-through; rr_ptr stays 0.

Optional Feature:
- Macro: MUL_SHARE_ARBITER_PERF_CNT_EN.
- When defined, add ports:
  - perf_clr  in  1  synchronous clear of both counters.
  - perf_busy_cnt  out  32  counts cycles with s1_vld|s2_vld.
  - perf_stall_cnt  out  32  counts cycles with !adv & |req_valid.
- Counter rules:
  - Both saturate at 0xFFFFFFFF.
  - Both reset to 0.
  - perf_clr has priority over increment.
- When not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Unsigned basic: req0 src1=7, src2=6, unsigned, rsp_ready=1 -> req_ready[0]=1 same cycle; two cycles later rsp_valid=1, rsp_data=42, rsp_id=0.
- Signedness: src1=0xFFFFFFFF, src2=2, both signed -> 0xFFFFFFFFFFFFFFFE. Same operands, both unsigned -> 0x00000001FFFFFFFE.
- Round-robin: req0 and req1 held valid for 6 cycles, rsp_ready=1 -> grants 0,1,0,1,0,1; rsp_valid high for 6 consecutive cycles; ids 0,1,0,1,0,1.
- Back-pressure: 3 ops issued, rsp_ready=0 from the first response onward:
  - rsp_valid held, rsp_data/rsp_id stable, mul_in_en=mul_out_en=0, req_ready=0.
  - Raise rsp_ready -> 3 results drain on consecutive cycles, in order.
- Reset mid-flight: reset asserted with s1_vld=s2_vld=1 -> rsp_valid=0 and mul_aclr=1 in the same cycle, no response after release; next grant goes to requester 0 first.
- Perf (macro defined): 4 busy cycles plus 2 stalled cycles with a pending request -> perf_busy_cnt=6, perf_stall_cnt=2; perf_clr pulse -> both 0 next cycle.
